keypad_entry_ctrl: RTL and testbench
====================================

Name: keypad_entry_ctrl

Overview:
Sequences the on-screen 3x4 POS keypad. It samples the cursor position when the select button is pressed and maps the cell to a key. Digits are accumulated into a BCD entry buffer that drives the display. A completed amount is handed to the transaction logic over a valid/ready handshake. An inactivity timeout auto-clears abandoned entries.

Parameters:
MAX_DIGITS, 6, capacity of the BCD entry buffer in digits (1..8).
TIMEOUT_CYC, 50_000_000, idle cycles in ENTRY before auto-clear (>=2).

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
cursor_x  in  4  cursor column; 0..2 valid, 3 reachable but invalid
cursor_y  in  4  cursor row; 0..3 valid
btn_sel  in  1  select button, active-low
btn_clr  in  1  full-clear button, active-low
out_ready  in  1  consumer ready
out_valid  out  1  entered amount available
out_bcd  out  4*MAX_DIGITS  entered amount, BCD, least-significant digit in [3:0]
out_ndigits  out  4  digit count of out_bcd
disp_bcd  out  4*MAX_DIGITS  live entry buffer for display
digit_cnt  out  4  digits currently in buffer
entry_busy  out  1  high in ENTRY or OUTPUT
err  out  1  one-cycle pulse on rejected key
timeout  out  1  one-cycle pulse on auto-clear

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous, active-low. Reset forces:
  - every output to 0;
  - state to IDLE;
  - buffer, count and timeout counter to 0;
  - button history registers to 1, so a button held low through reset release produces no press.
- Press detect: press = current input low AND previous sample high. Evaluated combinationally against the registered history. The action is applied at that same rising edge and is visible one cycle later. Cursor is sampled at the press edge.
- Key map, cell (x,y):
  - (0..2,0) = 1 2 3
  - (0..2,1) = 4 5 6
  - (0..2,2) = 7 8 9
  - (0,3) = BKSP, (1,3) = 0, (2,3) = ENT
  - x>2 or y>3: invalid cell, pulse err, no other change.
- Simultaneous btn_sel and btn_clr press: btn_clr wins; the sel press is discarded.
- State IDLE (buffer 0, cnt 0):
  - digit 1-9: buffer = digit, cnt = 1, go to ENTRY.
  - digit 0: ignored, no err (no leading zero).
  - BKSP: ignored.
  - ENT: err.
  - btn_clr: no-op.
- State ENTRY:
  - digit: if cnt < MAX_DIGITS, buffer = {buffer shifted left 4, digit} and cnt+1. Otherwise err, buffer unchanged.
  - BKSP: buffer shifted right 4, cnt-1. If cnt becomes 0, go to IDLE.
  - btn_clr: buffer 0, cnt 0, go to IDLE.
  - ENT: out_bcd = buffer, out_ndigits = cnt, out_valid = 1, go to OUTPUT. disp_bcd holds its value.
  - Timeout counter:
    - reset to 0 on entering ENTRY and on every accepted or rejected press;
    - otherwise increments each cycle;
    - at the edge where the counter equals TIMEOUT_CYC-1: clear the buffer, go to IDLE, pulse timeout on the next cycle.
- State OUTPUT:
  - out_valid stays high. out_bcd and out_ndigits are stable.
  - All presses are ignored, including btn_clr. No err. No timeout.
  - At an edge with out_valid and out_ready: out_valid = 0, buffer and cnt = 0, go to IDLE.
  - out_ready while not valid: ignored.
- entry_busy = (state != IDLE), registered.
- err and timeout never assert in the same cycle. Each lasts exactly one cycle.
- Reset mid-operation (any state) returns to reset values immediately. A pending output is discarded.

Test Plan:
1. MAX_DIGITS=6, out_ready=1. Select (0,0),(1,0),(2,0), then (2,3) → out_valid high exactly 1 cycle, out_bcd=0x000123, out_ndigits=3, then IDLE with disp_bcd=0.
2. Select (2,2) seven times → disp_bcd=0x999999, digit_cnt=6. err pulses only on the 7th press.
3. Enter 5 then ENT with out_ready=0 for 10 cycles; press (0,0) and btn_clr meanwhile → out_valid held, out_bcd=0x5 unchanged, no err. Raise out_ready → out_valid drops the next cycle, IDLE.
4. TIMEOUT_CYC=16. Select (0,1) (digit 4), then idle → buffer clears at the 16th edge after the press, and timeout pulses the following cycle. Repeat with a press at cycle 10 → the clear moves to 16 edges after that press.
5. Enter 1,2, then BKSP → disp_bcd=0x1, cnt=1. BKSP → IDLE. ENT in IDLE → err. Select with cursor_x=3 → err, no state change. Select (1,3) in IDLE → no change, no err.
6. Assert rst_n low during OUTPUT → out_valid=0 and entry_busy=0 asynchronously. Hold btn_sel low across reset release → no press registered.

Source files
------------

// File: rtl/keypad_entry_ctrl.sv
// POS keypad entry sequencer: maps cursor cell to a key on select press, builds a BCD
// amount, hands it off over valid/ready and auto-clears an abandoned entry.
module keypad_entry_ctrl #(
  parameter int MAX_DIGITS  = 6,
  parameter int TIMEOUT_CYC = 50_000_000
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [3:0]              cursor_x,
  input  logic [3:0]              cursor_y,
  input  logic                    btn_sel,
  input  logic                    btn_clr,
  input  logic                    out_ready,
  output logic                    out_valid,
  output logic [4*MAX_DIGITS-1:0] out_bcd,
  output logic [3:0]              out_ndigits,
  output logic [4*MAX_DIGITS-1:0] disp_bcd,
  output logic [3:0]              digit_cnt,
  output logic                    entry_busy,
  output logic                    err,
  output logic                    timeout
);

  // state   | meaning
  // S_IDLE   | buffer empty, waiting for a leading non-zero digit
  // S_ENTRY  | digits being entered, inactivity timer running
  // S_OUTPUT | amount presented on out_*, waiting for out_ready

  localparam int BW = 4 * MAX_DIGITS;
  localparam int TW = $clog2(TIMEOUT_CYC);
  localparam logic [TW-1:0] TMR_LOAD = TW'(TIMEOUT_CYC - 1);
  localparam logic [3:0] MAX_CNT  = 4'(MAX_DIGITS);
  localparam logic [3:0] KEY_BKSP = 4'd10;
  localparam logic [3:0] KEY_ENT  = 4'd11;
  localparam logic [3:0] KEY_BAD  = 4'd15;

  typedef enum logic [1:0] {S_IDLE, S_ENTRY, S_OUTPUT} state_t;

  state_t          state;
  logic            sel_held_q;
  logic            clr_held_q;
  logic [TW-1:0]   tmr;
  logic [3:0]      key;
  logic            key_digit;
  logic            press_sel;
  logic            press_clr;
  logic [BW+3:0]   shl_ext;

  // History registers hold "button was low"; resetting them to 1 means a button
  // already held down when reset releases is not seen as a fresh press.
  assign press_sel = ~btn_sel & ~sel_held_q;
  assign press_clr = ~btn_clr & ~clr_held_q;
  assign shl_ext   = {disp_bcd, key};
  assign key_digit = (key <= 4'd9);

  always_comb begin
    key = KEY_BAD;
    if (cursor_x <= 4'd2 && cursor_y <= 4'd3) begin
      if (cursor_y == 4'd3) begin
        case (cursor_x)
          4'd0:    key = KEY_BKSP;
          4'd1:    key = 4'd0;
          default: key = KEY_ENT;
        endcase
      end else begin
        key = cursor_y * 4'd3 + cursor_x + 4'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      sel_held_q  <= 1'b1;
      clr_held_q  <= 1'b1;
      tmr         <= '0;
      disp_bcd    <= '0;
      digit_cnt   <= '0;
      out_valid   <= 1'b0;
      out_bcd     <= '0;
      out_ndigits <= '0;
      entry_busy  <= 1'b0;
      err         <= 1'b0;
      timeout     <= 1'b0;
    end else begin
      sel_held_q <= ~btn_sel;
      clr_held_q <= ~btn_clr;
      err        <= 1'b0;
      timeout    <= 1'b0;
      case (state)
        S_IDLE: begin
          if (!press_clr && press_sel) begin
            if (key == KEY_BAD || key == KEY_ENT) begin
              err <= 1'b1;
            end else if (key_digit && key != 4'd0) begin
              disp_bcd   <= BW'(key);
              digit_cnt  <= 4'd1;
              tmr        <= TMR_LOAD;
              state      <= S_ENTRY;
              entry_busy <= 1'b1;
            end
          end
        end
        S_ENTRY: begin
          if (press_clr) begin
            disp_bcd   <= '0;
            digit_cnt  <= '0;
            state      <= S_IDLE;
            entry_busy <= 1'b0;
          end else if (press_sel) begin
            tmr <= TMR_LOAD;
            if (key == KEY_BAD) begin
              err <= 1'b1;
            end else if (key_digit) begin
              if (digit_cnt < MAX_CNT) begin
                disp_bcd  <= shl_ext[BW-1:0];
                digit_cnt <= digit_cnt + 4'd1;
              end else begin
                err <= 1'b1;
              end
            end else if (key == KEY_BKSP) begin
              disp_bcd  <= disp_bcd >> 4;
              digit_cnt <= digit_cnt - 4'd1;
              if (digit_cnt == 4'd1) begin
                state      <= S_IDLE;
                entry_busy <= 1'b0;
              end
            end else begin
              out_bcd     <= disp_bcd;
              out_ndigits <= digit_cnt;
              out_valid   <= 1'b1;
              state       <= S_OUTPUT;
            end
          end else if (tmr == '0) begin
            disp_bcd   <= '0;
            digit_cnt  <= '0;
            timeout    <= 1'b1;
            state      <= S_IDLE;
            entry_busy <= 1'b0;
          end else begin
            tmr <= tmr - 1'b1;
          end
        end
        S_OUTPUT: begin
          if (out_ready) begin
            out_valid  <= 1'b0;
            disp_bcd   <= '0;
            digit_cnt  <= '0;
            state      <= S_IDLE;
            entry_busy <= 1'b0;
          end
        end
        default: begin
          state      <= S_IDLE;
          entry_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_keypad_entry_ctrl.sv
// Scoreboard bench for keypad_entry_ctrl: directed scenarios plus random presses,
// checked per cycle against a digit-list reference model.
module tb_keypad_entry_ctrl;
  localparam int MD = 6;
  localparam int TO = 16;
  localparam int BW = 4 * MD;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [3:0]    cursor_x, cursor_y;
  logic          btn_sel, btn_clr, out_ready;
  logic          out_valid, entry_busy, err, timeout;
  logic [BW-1:0] out_bcd, disp_bcd;
  logic [3:0]    out_ndigits, digit_cnt;

  keypad_entry_ctrl #(.MAX_DIGITS(MD), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rst_n(rst_n), .cursor_x(cursor_x), .cursor_y(cursor_y),
    .btn_sel(btn_sel), .btn_clr(btn_clr), .out_ready(out_ready),
    .out_valid(out_valid), .out_bcd(out_bcd), .out_ndigits(out_ndigits),
    .disp_bcd(disp_bcd), .digit_cnt(digit_cnt), .entry_busy(entry_busy),
    .err(err), .timeout(timeout)
  );

  always #5 clk = ~clk;

  typedef struct { logic [BW-1:0] bcd; int nd; } exp_t;
  exp_t sb_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  // reference model: entered digits (front = most significant)
  int digits[$];
  bit m_pend, m_sel_low, m_clr_low, m_err, m_to;
  int m_idle;

  task automatic chk(input string name, input longint act, input longint exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [BW-1:0] packed_digits();
    logic [BW-1:0] v = '0;
    foreach (digits[i]) v = (v << 4) | BW'(digits[i]);
    return v;
  endfunction

  function automatic int keymap(input int x, input int y);
    if (x > 2 || y > 3) return -1;
    if (y < 3) return 3 * y + x + 1;
    return (x == 0) ? 10 : (x == 1) ? 0 : 11;
  endfunction

  task automatic model_reset();
    digits.delete();
    sb_q.delete();
    m_pend = 0; m_idle = 0; m_err = 0; m_to = 0;
    m_sel_low = 1; m_clr_low = 1;
  endtask

  task automatic model_step();
    bit psel, pclr;
    int k;
    psel = !btn_sel && !m_sel_low;
    pclr = !btn_clr && !m_clr_low;
    m_sel_low = !btn_sel;
    m_clr_low = !btn_clr;
    m_err = 0; m_to = 0;
    if (m_pend) begin
      if (out_ready) begin m_pend = 0; digits.delete(); end
    end else if (pclr) begin
      digits.delete(); m_idle = 0;
    end else if (psel) begin
      m_idle = 0;
      k = keymap(int'(cursor_x), int'(cursor_y));
      if (k < 0) m_err = 1;
      else if (k <= 9) begin
        if (digits.size() == 0 && k == 0) ;
        else if (digits.size() < MD) digits.push_back(k);
        else m_err = 1;
      end else if (k == 10) begin
        if (digits.size() > 0) void'(digits.pop_back());
      end else begin
        if (digits.size() == 0) m_err = 1;
        else begin
          m_pend = 1;
          sb_q.push_back('{bcd: packed_digits(), nd: digits.size()});
        end
      end
    end else if (digits.size() > 0) begin
      if (m_idle == TO - 1) begin digits.delete(); m_to = 1; m_idle = 0; end
      else m_idle++;
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
    model_step();
    chk("disp_bcd", disp_bcd, packed_digits());
    chk("digit_cnt", digit_cnt, digits.size());
    chk("entry_busy", entry_busy, (m_pend || digits.size() > 0) ? 1 : 0);
    chk("out_valid", out_valid, m_pend);
    chk("err", err, m_err);
    chk("timeout", timeout, m_to);
  endtask

  task automatic press(input int x, input int y);
    cursor_x = 4'(x); cursor_y = 4'(y);
    btn_sel = 1'b0; tick();
    btn_sel = 1'b1; tick();
  endtask

  task automatic press_clr();
    btn_clr = 1'b0; tick();
    btn_clr = 1'b1; tick();
  endtask

  task automatic do_reset();
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_entry_busy", entry_busy, 0);
    chk("rst_disp_bcd", disp_bcd, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  // scoreboard monitor: a transfer happens at the next edge when valid && ready
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (sb_q.size() == 0) begin
        n_tests++; n_fail++;
        $display("FAIL unexpected_output: got %0h/%0d expected none", out_bcd, out_ndigits);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        chk("out_bcd", out_bcd, e.bcd);
        chk("out_ndigits", out_ndigits, e.nd);
      end
    end
  end

  initial begin
    rst_n = 1'b0; btn_sel = 1'b1; btn_clr = 1'b1; out_ready = 1'b1;
    cursor_x = '0; cursor_y = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("reset_out_valid", out_valid, 0);
    chk("reset_out_bcd", out_bcd, 0);
    chk("reset_out_ndigits", out_ndigits, 0);
    chk("reset_disp", disp_bcd, 0);
    chk("reset_cnt", digit_cnt, 0);
    chk("reset_busy", entry_busy, 0);
    chk("reset_err", err, 0);
    chk("reset_timeout", timeout, 0);
    rst_n = 1'b1;
    tick();

    // 1: 1,2,3 ENT with out_ready high
    press(0, 0); press(1, 0); press(2, 0); press(2, 3);
    repeat (3) tick();

    // 2: overfill with 9s, then hand it off
    repeat (7) press(2, 2);
    press(2, 3);
    repeat (2) tick();

    // 3: output held while consumer stalls; presses and clear ignored
    out_ready = 1'b0;
    press(1, 1); press(2, 3); press(0, 0); press_clr();
    repeat (10) tick();
    out_ready = 1'b1;
    repeat (3) tick();

    // 4: inactivity timeout, then a press that pushes it out
    press(0, 1);
    repeat (20) tick();
    press(0, 1);
    repeat (8) tick();
    press(1, 0);
    repeat (20) tick();

    // 5: backspace, ENT in idle, invalid cells, leading zero
    press(0, 0); press(1, 0); press(0, 3); press(0, 3);
    press(2, 3); press(3, 1); press(1, 3); press(1, 4); press(0, 3);
    press(3, 0); press(2, 0); press(3, 3); press(1, 4); press(1, 3); press(0, 3); press(0, 3);

    // 6: reset while an output is pending, select held low across release
    out_ready = 1'b0;
    press(1, 1); press(2, 3);
    tick();
    btn_sel = 1'b0; cursor_x = 4'd0; cursor_y = 4'd0;
    do_reset();
    repeat (3) tick();
    btn_sel = 1'b1;
    tick();
    out_ready = 1'b1;

    // random phase
    for (int i = 0; i < 400; i++) begin
      int r;
      r = $urandom_range(0, 19);
      if (r == 0) begin
        do_reset();
      end else if (r < 4) begin
        btn_sel = 1'b1; btn_clr = 1'b1;
        repeat ($urandom_range(5, 25)) tick();
      end else begin
        repeat (8) begin
          btn_sel   = 1'($urandom_range(0, 1));
          btn_clr   = ($urandom_range(0, 9) != 0);
          cursor_x  = 4'($urandom_range(0, 3));
          cursor_y  = 4'($urandom_range(0, 4));
          out_ready = 1'($urandom_range(0, 1));
          tick();
        end
      end
    end

    btn_sel = 1'b1; btn_clr = 1'b1; out_ready = 1'b1;
    repeat (5) tick();
    chk("sb_drain", sb_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
